// File: rtl/dram_burst_arbiter.sv
// Round-robin burst arbiter in front of a single-port, byte-addressed DRAM
// with a 1-cycle registered read. One requester owns the DRAM per burst; beats
// step the word address by 4 and wrap modulo 2^ADDR_WIDTH.
module dram_burst_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               cmd_valid,
  output logic [NUM_REQ-1:0]               cmd_ready,
  input  logic [NUM_REQ-1:0]               cmd_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    cmd_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]     cmd_len,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    wr_data,
  input  logic [NUM_REQ-1:0]               wr_valid,
  output logic [NUM_REQ-1:0]               wr_ready,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic [NUM_REQ-1:0]               rd_valid,
  output logic [NUM_REQ-1:0]               done,
  output logic                             dram_we,
  output logic [ADDR_WIDTH-1:0]            dram_addr,
  output logic [DATA_WIDTH-1:0]            dram_din,
  input  logic [DATA_WIDTH-1:0]            dram_dout
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ, FINISH} state_t;

  state_t                state_reg, state_next;
  logic [ID_W-1:0]       rr_reg, rr_next;
  logic [ID_W-1:0]       id_reg, id_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [LEN_WIDTH-1:0]  rem_reg, rem_next;
  logic                  rdv_reg, rdv_next;

  logic                  found;
  logic                  accept;
  logic [ID_W-1:0]       win;
  logic [ID_W-1:0]       cand;
  logic                  beat_we;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [DATA_WIDTH-1:0] beat_din;

  // Requester index base+ofs, wrapped into 0..NUM_REQ-1 (ofs is 1..NUM_REQ).
  function automatic logic [ID_W-1:0] wrap_id(input logic [ID_W-1:0] base, input int ofs);
    int s;
    s = int'(base) + ofs;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // Arbitration search, burst sequencing and DRAM beat generation.
  always_comb begin
    state_next = state_reg;
    rr_next    = rr_reg;
    id_next    = id_reg;
    addr_next  = addr_reg;
    rem_next   = rem_reg;
    rdv_next   = 1'b0;
    found      = 1'b0;
    accept     = 1'b0;
    win        = '0;
    cand       = '0;
    beat_we    = 1'b0;
    beat_addr  = '0;
    beat_din   = '0;

    // First asserted request after the last winner gets the grant.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = wrap_id(rr_reg, k);
      if (!found && cmd_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end

    case (state_reg)
      IDLE: begin
        if (found) begin
          accept     = 1'b1;
          id_next    = win;
          rr_next    = win;
          addr_next  = {cmd_addr[int'(win)*ADDR_WIDTH + 2 +: ADDR_WIDTH-2], 2'b00};
          rem_next   = cmd_len[int'(win)*LEN_WIDTH +: LEN_WIDTH];
          state_next = cmd_we[win] ? WRITE : READ;
        end
      end
      WRITE: begin
        // Owner paces the burst; a low wr_valid simply stalls.
        if (wr_valid[id_reg]) begin
          beat_we   = 1'b1;
          beat_addr = addr_reg;
          beat_din  = wr_data[int'(id_reg)*DATA_WIDTH +: DATA_WIDTH];
          addr_next = addr_reg + ADDR_WIDTH'(4);
          if (rem_reg == '0) state_next = FINISH;
          else               rem_next   = rem_reg - LEN_WIDTH'(1);
        end
      end
      READ: begin
        // One read per cycle; the owner has no way to push back.
        beat_addr = addr_reg;
        addr_next = addr_reg + ADDR_WIDTH'(4);
        rdv_next  = 1'b1;
        if (rem_reg == '0) state_next = FINISH;
        else               rem_next   = rem_reg - LEN_WIDTH'(1);
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and burst bookkeeping registers; reset aborts any burst in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      rr_reg    <= ID_W'(NUM_REQ-1);
      id_reg    <= '0;
      addr_reg  <= '0;
      rem_reg   <= '0;
      rdv_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      rr_reg    <= rr_next;
      id_reg    <= id_next;
      addr_reg  <= addr_next;
      rem_reg   <= rem_next;
      rdv_reg   <= rdv_next;
    end
  end

  // Per-requester handshake decode, all forced low while rst is held.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign cmd_ready[gi] = ~rst & accept & (win == ID_W'(gi));
      assign wr_ready[gi]  = ~rst & (state_reg == WRITE) & (id_reg == ID_W'(gi));
      assign rd_valid[gi]  = ~rst & rdv_reg & (id_reg == ID_W'(gi));
      assign done[gi]      = ~rst & (state_reg == FINISH) & (id_reg == ID_W'(gi));
    end
  endgenerate

  assign dram_we   = ~rst & beat_we;
  assign dram_addr = rst ? '0 : beat_addr;
  assign dram_din  = rst ? '0 : beat_din;
  // The DRAM's registered output lines up with rd_valid one cycle after issue.
  assign rd_data   = dram_dout;

endmodule

// File: tb/tb_dram_burst_arbiter.sv
// Bench for dram_burst_arbiter: DRAM model, burst table, corner sequences and
// randomized bursts against a shadow memory plus a round-robin grant model.
module tb_dram_burst_arbiter;

  localparam int N  = 2;
  localparam int AW = 20;
  localparam int DW = 32;
  localparam int LW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    cmd_valid, cmd_ready, cmd_we;
  logic [N*AW-1:0] cmd_addr;
  logic [N*LW-1:0] cmd_len;
  logic [N*DW-1:0] wr_data;
  logic [N-1:0]    wr_valid, wr_ready, rd_valid, done;
  logic [DW-1:0]   rd_data;
  logic            dram_we;
  logic [AW-1:0]   dram_addr;
  logic [DW-1:0]   dram_din;
  logic [DW-1:0]   dram_dout;

  always #5 clk = ~clk;

  dram_burst_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done),
    .dram_we(dram_we), .dram_addr(dram_addr), .dram_din(dram_din), .dram_dout(dram_dout)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;
  int last_grant;
  logic [31:0] shadow [int];

  // Power-on DRAM contents, including the three preloaded words at 0x100.
  function automatic logic [31:0] init_pat(input logic [17:0] i);
    case (i)
      18'h00040: return 32'h11111111;
      18'h00041: return 32'h22222222;
      18'h00042: return 32'h33333333;
      default:   return {14'h1A5, i};
    endcase
  endfunction

  // DRAM model: byte addressed, word wide, registered read.
  logic [31:0] mem [0:(1<<18)-1];
  initial for (int i = 0; i < (1<<18); i++) mem[i] = init_pat(18'(i));
  always @(posedge clk) begin
    if (dram_we) mem[dram_addr[19:2]] <= dram_din;
    dram_dout <= mem[dram_addr[19:2]];
  end

  function automatic logic [31:0] ref_word(input logic [19:0] a);
    logic [19:0] wa;
    wa = {a[19:2], 2'b00};
    if (shadow.exists(int'(wa))) return shadow[int'(wa)];
    return init_pat(a[19:2]);
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  // Round-robin rule: first valid requester after the previous winner.
  function automatic int model_winner(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(last_grant + k) % N]) return (last_grant + k) % N;
    end
    return 0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives and checks one burst, starting in its accept cycle (after the
  // grant was sampled) and returning in the IDLE cycle after FINISH.
  task automatic run_owned(input int req, input bit we, input logic [19:0] addr, input int len,
                           input int stall_at, input int stall_n, input logic [31:0] dbase,
                           input bit rnd, input bit keep,
                           output int done_at, output logic [19:0] first_a, output logic [19:0] last_a);
    logic [19:0] base, ea;
    logic [31:0] d;
    int rel, b, stalled, npulse;
    base = {addr[19:2], 2'b00};
    ea = base;
    rel = 1; b = 0; stalled = 0; npulse = 0;
    first_a = '0; last_a = '0;
    step();
    if (!keep) cmd_valid = '0;
    if (we) begin
      while (b <= len) begin
        for (int o = 0; o < N; o++) begin
          if (o != req) begin
            wr_valid[o] = 1'($urandom_range(0, 1));
            wr_data[o*DW +: DW] = $urandom;
          end
        end
        ea = base + 20'(4*b);
        if (b == stall_at && stalled < stall_n) begin
          wr_valid[req] = 1'b0;
          stalled++;
          @(negedge clk);
          check("stall_no_we", dram_we, 0);
        end else begin
          d = rnd ? $urandom : dbase + 32'(b);
          wr_valid[req] = 1'b1;
          wr_data[req*DW +: DW] = d;
          @(negedge clk);
          check("wr_we", dram_we, 1);
          check("wr_addr", dram_addr, ea);
          check("wr_din", dram_din, d);
          if (b == 0) first_a = dram_addr;
          last_a = dram_addr;
          shadow[int'(ea)] = d;
          b++;
        end
        check("wr_ready", wr_ready, oh(req));
        check("busy_cmd_ready", cmd_ready, 0);
        check("busy_done", done, 0);
        if (dram_we) npulse++;
        step();
        rel++;
      end
      wr_valid = '0;
    end else begin
      for (int k = 0; k <= len; k++) begin
        @(negedge clk);
        ea = base + 20'(4*k);
        check("rd_issue_we", dram_we, 0);
        check("rd_addr", dram_addr, ea);
        if (k == 0) begin
          check("rd_valid_first", rd_valid, 0);
          first_a = dram_addr;
        end else begin
          check("rd_valid", rd_valid, oh(req));
          check("rd_data", rd_data, ref_word(ea - 20'd4));
        end
        last_a = dram_addr;
        check("busy_cmd_ready", cmd_ready, 0);
        check("busy_done", done, 0);
        step();
        rel++;
      end
    end
    @(negedge clk);
    check("done", done, oh(req));
    check("finish_we", dram_we, 0);
    check("finish_cmd_ready", cmd_ready, 0);
    if (we) begin
      check("finish_rd_valid", rd_valid, 0);
      check("we_pulses", npulse, len + 1);
    end else begin
      check("last_rd_valid", rd_valid, oh(req));
      check("last_rd_data", rd_data, ref_word(ea));
    end
    done_at = rel;
    $display("burst req=%0d we=%0d addr=%05h len=%0d done_at=%0d", req, we, addr, len, done_at);
    step();
  endtask

  typedef struct {
    int          req;
    bit          we;
    logic [19:0] addr;
    int          len;
    int          stall_at;
    int          stall_n;
    logic [31:0] dbase;
    int          exp_done;
    logic [19:0] exp_first;
    logic [19:0] exp_last;
  } vec_t;

  vec_t vt [6];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, da, acc, prev;
    logic [19:0] fa, la;
    logic [19:0] ra [N];
    int rl [N];
    bit rw [N];
    int sa, sn;
    logic [N-1:0] mask;

    vt[0] = '{0, 1'b0, 20'h00100, 2, -1, 0, 32'h0,  4, 20'h00100, 20'h00108};
    vt[1] = '{1, 1'b1, 20'h00200, 3,  1, 2, 32'hA0, 7, 20'h00200, 20'h0020C};
    vt[2] = '{0, 1'b0, 20'h00200, 3, -1, 0, 32'h0,  5, 20'h00200, 20'h0020C};
    vt[3] = '{1, 1'b1, 20'hFFFFE, 1, -1, 0, 32'h55, 3, 20'hFFFFC, 20'h00000};
    vt[4] = '{0, 1'b0, 20'hFFFFC, 1, -1, 0, 32'h0,  3, 20'hFFFFC, 20'h00000};
    vt[5] = '{1, 1'b0, 20'h00103, 0, -1, 0, 32'h0,  2, 20'h00100, 20'h00100};

    // Reset, with requests and write beats already pending.
    rst = 1'b1;
    cmd_valid = '1;
    cmd_we = '0;
    cmd_addr = {20'h00104, 20'h00100};
    cmd_len = '0;
    wr_valid = '1;
    wr_data = {32'hDEADBEEF, 32'hCAFEF00D};
    repeat (2) step();
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_done", done, 0);
    check("rst_dram_we", dram_we, 0);
    check("rst_dram_addr", dram_addr, 0);
    check("rst_dram_din", dram_din, 0);
    step();
    rst = 1'b0;
    wr_valid = '0;
    last_grant = N - 1;

    // Contention: both hold 1-word reads; grants must alternate 0,1,0,1.
    for (int g = 0; g < 4; g++) begin
      @(negedge clk);
      w = model_winner(cmd_valid);
      check("cont_grant_model", cmd_ready, oh(w));
      check("cont_grant_order", cmd_ready, oh(g % 2));
      last_grant = w;
      run_owned(w, 1'b0, cmd_addr[w*AW +: AW], 0, -1, 0, 32'h0, 1'b0, 1'b1, da, fa, la);
      check("cont_done_at", da, 2);
    end
    cmd_valid = '0;

    // Table of single-requester bursts.
    for (int i = 0; i < 6; i++) begin
      vec_t v;
      v = vt[i];
      cmd_valid = '0;
      cmd_valid[v.req] = 1'b1;
      cmd_we[v.req] = v.we;
      cmd_addr[v.req*AW +: AW] = v.addr;
      cmd_len[v.req*LW +: LW] = LW'(v.len);
      @(negedge clk);
      w = model_winner(cmd_valid);
      check("tbl_grant", cmd_ready, oh(w));
      last_grant = w;
      run_owned(w, v.we, v.addr, v.len, v.stall_at, v.stall_n, v.dbase, 1'b0, 1'b0, da, fa, la);
      check("tbl_done_at", da, v.exp_done);
      check("tbl_first_addr", fa, v.exp_first);
      check("tbl_last_addr", la, v.exp_last);
    end

    // Back-to-back 1-word writes from req0 holding cmd_valid.
    cmd_valid = 2'b01;
    cmd_we[0] = 1'b1;
    cmd_addr[0 +: AW] = 20'h00400;
    cmd_len[0 +: LW] = '0;
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("b2b_grant", cmd_ready, 2'b01);
      acc = cyc;
      if (k > 0) check("b2b_period", acc - prev, 3);
      prev = acc;
      last_grant = 0;
      run_owned(0, 1'b1, 20'h00400, 0, -1, 0, 32'h0, 1'b1, 1'b1, da, fa, la);
      check("b2b_done_at", da, 2);
    end
    cmd_valid = '0;

    // Reset in beat 2 of an 8-word read, then both request.
    cmd_valid = 2'b01;
    cmd_we[0] = 1'b0;
    cmd_addr[0 +: AW] = 20'h00500;
    cmd_len[0 +: LW] = 8'd7;
    @(negedge clk);
    check("mr_grant", cmd_ready, 2'b01);
    last_grant = 0;
    step();
    cmd_valid = '0;
    @(negedge clk);
    check("mr_beat1_addr", dram_addr, 20'h00500);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("mr_rst_rd_valid", rd_valid, 0);
    check("mr_rst_done", done, 0);
    check("mr_rst_we", dram_we, 0);
    step();
    rst = 1'b0;
    last_grant = N - 1;
    cmd_valid = 2'b11;
    cmd_we = '0;
    cmd_addr = {20'h00504, 20'h00500};
    cmd_len = '0;
    @(negedge clk);
    check("mr_idle_grant", cmd_ready, 2'b01);
    check("mr_idle_rd_valid", rd_valid, 0);
    check("mr_idle_done", done, 0);
    check("mr_idle_we", dram_we, 0);
    last_grant = 0;
    run_owned(0, 1'b0, 20'h00500, 0, -1, 0, 32'h0, 1'b0, 1'b0, da, fa, la);
    check("mr_done_at", da, 2);

    // Randomized bursts with random contention, stalls and wrap addresses.
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < N; i++) begin
        rw[i] = 1'($urandom_range(0, 1));
        ra[i] = ($urandom_range(0, 7) == 0) ? 20'hFFFF0 + 20'($urandom_range(0, 15))
                                           : 20'h03000 + 20'($urandom_range(0, 255));
        rl[i] = $urandom_range(0, 4);
        cmd_we[i] = rw[i];
        cmd_addr[i*AW +: AW] = ra[i];
        cmd_len[i*LW +: LW] = LW'(rl[i]);
      end
      mask = N'($urandom_range(1, (1 << N) - 1));
      cmd_valid = mask;
      @(negedge clk);
      w = model_winner(mask);
      check("rnd_grant", cmd_ready, oh(w));
      last_grant = w;
      sa = $urandom_range(0, rl[w]);
      sn = $urandom_range(0, 2);
      run_owned(w, rw[w], ra[w], rl[w], sa, sn, 32'h0, 1'b1, 1'b0, da, fa, la);
      check("rnd_done_at", da, rl[w] + 2 + (rw[w] ? sn : 0));
      check("rnd_first_addr", fa, {ra[w][19:2], 2'b00});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dram_burst_arbiter.md
Name: dram_burst_arbiter

Overview:
- Shares the single-port, byte-addressed, 32-bit-word DRAM model between NUM_REQ requesters, e.g. ifmap/weight loaders and the psum writeback unit.
- Each requester issues a burst command (start address, word count, direction). The block grants requesters round-robin and sequences consecutive word accesses at address +4 per beat.
- It absorbs the DRAM's 1-cycle registered read latency and returns read data with a per-requester valid.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
ADDR_WIDTH, 20, DRAM byte-address width
DATA_WIDTH, 32, word width (DRAM din/dout width)
LEN_WIDTH, 8, burst length field width; burst = cmd_len+1 words

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  NUM_REQ  per-requester command valid
cmd_ready  out  NUM_REQ  per-requester command accept (one-hot or zero)
cmd_we  in  NUM_REQ  1 = write burst, 0 = read burst
cmd_addr  in  NUM_REQ*ADDR_WIDTH  start byte address; bits [1:0] ignored (forced 0)
cmd_len  in  NUM_REQ*LEN_WIDTH  words minus one
wr_data  in  NUM_REQ*DATA_WIDTH  write beat data
wr_valid  in  NUM_REQ  write beat valid
wr_ready  out  NUM_REQ  write beat accept
rd_data  out  DATA_WIDTH  read data, shared by all requesters
rd_valid  out  NUM_REQ  read data valid, one-hot to the owner
done  out  NUM_REQ  1-cycle pulse at burst completion
dram_we  out  1  DRAM write enable
dram_addr  out  ADDR_WIDTH  DRAM byte address
dram_din  out  DATA_WIDTH  DRAM write data
dram_dout  in  DATA_WIDTH  DRAM read data (registered, 1-cycle latency)

Behaviour:
- One clock domain: clk. Reset: synchronous, active-high rst.
- Reset values: state=IDLE; rr pointer=NUM_REQ-1, so requester 0 wins first.
  - cmd_ready, wr_ready, rd_valid, done, dram_we all 0.
  - dram_addr=0, dram_din=0.
  - While rst is high, dram_we is 0 regardless of state.
- State IDLE:
  - Winner = first asserted cmd_valid searching from rr+1 upward, modulo NUM_REQ.
  - cmd_ready[winner]=1 combinationally in the same cycle; no other ready is set.
  - On accept, latch:
    - id=winner, rr=winner
    - we=cmd_we[id]
    - cur_addr={cmd_addr[id][ADDR_WIDTH-1:2],2'b00}
    - remaining=cmd_len[id]
  - Next state is WRITE (we=1) or READ (we=0).
  - No valid request: stay IDLE, dram_we=0.
- State WRITE:
  - wr_ready[id]=1; all other wr_ready are 0.
  - On wr_valid[id] in the same cycle: dram_we=1, dram_addr=cur_addr, dram_din=wr_data[id], cur_addr+=4.
  - If remaining==0, go to FINISH; else remaining-=1.
  - wr_valid low: stall, dram_we=0, no counter change.
- State READ:
  - Every cycle: dram_we=0, dram_addr=cur_addr, cur_addr+=4.
  - If remaining==0, go to FINISH; else remaining-=1.
  - A read issued in cycle N produces rd_valid[id]=1 with rd_data=dram_dout in cycle N+1.
  - No backpressure: the owner must sink one word per cycle.
- State FINISH:
  - done[id]=1 for exactly one cycle; next state IDLE.
  - For reads, the last rd_valid coincides with done.
  - cmd_ready is 0 in FINISH, so there is at least one IDLE cycle between bursts.
- Latency, read burst accepted in cycle T with cmd_len=L:
  - Issues in T+1..T+L+1.
  - rd_valid in T+2..T+L+2; done in T+L+2.
  - IDLE again at T+L+3.
- Latency, write burst with no stalls: beats in T+1..T+L+1, done in T+L+2.
- Address wrap: cur_addr increments modulo 2^ADDR_WIDTH; a burst crossing the top address continues from 0.
- cmd_* inputs of the owner are ignored after accept; the requester may change them.
- Non-owner wr_valid is ignored.
- rd_data may be driven to any value when no rd_valid is asserted.
- Reset mid-burst:
  - Aborts immediately; the next cycle is IDLE with no done pulse.
  - Pending read data is dropped (rd_valid=0).

Test Plan:
- Single read: DRAM preloaded with words 0x11111111,0x22222222,0x33333333 at 0x100/0x104/0x108. Req0 cmd_addr=0x100, cmd_len=2, read. -> rd_valid[0] on 3 consecutive cycles with those words; done[0] with the 3rd word; dram_addr sequence 0x100,0x104,0x108.
- Write with stalls: req1 writes cmd_addr=0x200, cmd_len=3, data 0xA0..0xA3, wr_valid low for 2 cycles after beat 1. -> exactly 4 dram_we pulses, none during the stall. Read-back returns 0xA0..0xA3 at 0x200..0x20C; done[1] once.
- Contention: both requesters assert cmd_valid in the cycle after reset, each with a 1-word read. -> grants in order 0, 1, 0, 1 over four bursts; never two cmd_ready bits high together.
- Misalignment and wrap (ADDR_WIDTH=20): cmd_addr=0xFFFFE (bits [1:0] forced 0), cmd_len=1, write. -> dram_addr 0xFFFFC then 0x00000.
- Reset mid-burst: assert rst during beat 2 of an 8-word read. -> next cycle IDLE, rd_valid and done stay 0, dram_we=0. A new request after reset is granted to requester 0.
- Back-to-back: req0 holds cmd_valid continuously with 1-word writes. -> one burst per 3 cycles (accept, beat, FINISH) with one IDLE cycle between them.
